cacheline_adapter: RTL and testbench
====================================

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter BEAT_W, default 64, memory beat width in bits; BEATS = LINE_W/BEAT_W (4 at defaults).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port dfp_addr  input  32  cache line request address.
REQ-006 SHALL have port dfp_read  input  1  line read request, held by cache until dfp_resp.
REQ-007 SHALL have port dfp_write  input  1  line write-back request, held by cache until dfp_resp.
REQ-008 SHALL have port dfp_wdata  input  LINE_W  write-back line data.
REQ-009 SHALL have port dfp_rdata  output  LINE_W  assembled read line.
REQ-010 SHALL have port dfp_resp  output  1  one-cycle completion pulse to cache.
REQ-011 SHALL have port bmem_addr  output  32  burst memory address.
REQ-012 SHALL have port bmem_read  output  1  burst read request.
REQ-013 SHALL have port bmem_write  output  1  burst write beat strobe.
REQ-014 SHALL have port bmem_wdata  output  BEAT_W  write beat data.
REQ-015 SHALL have port bmem_ready  input  1  memory can accept a new burst.
REQ-016 SHALL have port bmem_rdata  input  BEAT_W  read beat data.
REQ-017 SHALL have port bmem_rvalid  input  1  read beat valid.

Function
REQ-018 SHALL implement the states IDLE, RD_REQ, RD_BEAT, WR_BEAT and RESP.
REQ-019 IDLE: with bmem_ready=1 and dfp_write=1, SHALL latch the aligned address {dfp_addr[31:5],5'b0} and dfp_wdata, then go to WR_BEAT.
REQ-020 IDLE: with bmem_ready=1, dfp_read=1 and dfp_write=0, SHALL latch the aligned address and go to RD_REQ.
REQ-021 Simultaneous dfp_read and dfp_write: write wins; read is not serviced until re-presented after dfp_resp.
REQ-022 IDLE with bmem_ready=0: no transition, bmem outputs low.
REQ-023 RD_REQ: bmem_read=1 and bmem_addr=latched address for exactly one cycle, beat counter cleared, then RD_BEAT.
REQ-024 RD_BEAT: on each bmem_rvalid, bmem_rdata SHALL be written into line bits [BEAT_W*k +: BEAT_W] at counter k, and k increments.
REQ-025 After beat BEATS-1 is captured, next state SHALL be RESP.
REQ-026 Gaps (rvalid=0) inside RD_BEAT SHALL stall the counter with no timeout.
REQ-027 WR_BEAT: bmem_write=1 for BEATS consecutive cycles; bmem_addr holds the latched address; bmem_wdata = latched line bits [BEAT_W*k +: BEAT_W] at cycle k.
REQ-028 After beat BEATS-1, next state SHALL be RESP.
REQ-029 bmem_ready SHALL be sampled only in IDLE, never mid-burst.
REQ-030 RESP: dfp_resp=1 for exactly one cycle, then IDLE; requests present in RESP are ignored; earliest next acceptance is the cycle after dfp_resp.
REQ-031 Read latency: dfp_resp rises the cycle after the final rvalid.
REQ-032 Write latency: dfp_resp rises the cycle after the final write beat.
REQ-033 dfp_rdata SHALL hold the last assembled line until the next read burst overwrites it; it is unchanged by writes.
REQ-034 bmem_rvalid outside RD_BEAT SHALL be ignored.
REQ-035 Beat counter width SHALL be $clog2(BEATS) and SHALL wrap to 0 on leaving a burst.
REQ-036 bmem_read and bmem_write SHALL never be asserted in the same cycle.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, counter 0, dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0.
REQ-038 Reset mid-burst SHALL abort the burst with no dfp_resp; after release the block waits in IDLE for a fresh request.

Verification
REQ-039 Read: dfp_read, dfp_addr=0x1234_5678, bmem_ready=1, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> one bmem_read at 0x1234_5660; dfp_rdata={0x44..,0x33..,0x22..,0x11..}; dfp_resp one cycle after the 4th rvalid.
REQ-040 Write: dfp_write, dfp_addr=0x0000_0040, dfp_wdata=D -> bmem_write for 4 cycles, bmem_wdata=D[63:0],D[127:64],D[191:128],D[255:192]; dfp_resp the cycle after.
REQ-041 Gapped read: rvalid at cycles 3, 7, 8 and 12 -> beats placed in order; dfp_resp at cycle 13 only.
REQ-042 Not ready: dfp_read with bmem_ready=0 for 5 cycles -> no bmem activity; bmem_read the cycle after ready rises.
REQ-043 Conflict plus reset: dfp_read and dfp_write together -> write burst only. Then rst_n low after 2 write beats -> all outputs 0 at once, no dfp_resp.
REQ-044 Back-to-back: read held high through RESP -> exactly one dfp_resp per burst, next burst starts after the IDLE cycle.

Source files
------------

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - cache line to burst memory adapter
// Splits line write-backs into beats and assembles read beats into a full line.
module cacheline_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_BEAT, WR_BEAT, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   rline_q, rline_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // Write has priority over read when both are presented together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bmem_ready) begin
                    if (dfp_write)     state_d = WR_BEAT;
                    else if (dfp_read) state_d = RD_REQ;
                end
            end
            RD_REQ:  state_d = RD_BEAT;
            RD_BEAT: if (bmem_rvalid && cnt_q == LAST) state_d = RESP;
            WR_BEAT: if (cnt_q == LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            IDLE: begin
                if (bmem_ready && (dfp_write || dfp_read)) begin
                    addr_d = dfp_addr & 32'hFFFF_FFE0;
                    if (dfp_write) wline_d = dfp_wdata;
                end
            end
            RD_REQ: cnt_d = '0;
            RD_BEAT: begin
                if (bmem_rvalid) begin
                    rline_d[cnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
                    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
            end
            WR_BEAT: cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        case (state_q)
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
            end
            WR_BEAT: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wline_q[cnt_q*BEAT_W +: BEAT_W];
            end
            RESP:    dfp_resp = 1'b1;
            default: ;
        endcase
    end

    assign dfp_rdata = rline_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - directed self-checking bench for cacheline_adapter
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int total = 0;
    int bad   = 0;
    int k;

    localparam logic [255:0] L1 = {64'h4444444444444444, 64'h3333333333333333,
                                   64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] D1 = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                   64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
    localparam logic [255:0] L3 = {64'hA4A4A4A4A4A4A4A4, 64'hA3A3A3A3A3A3A3A3,
                                   64'hA2A2A2A2A2A2A2A2, 64'hA1A1A1A1A1A1A1A1};
    localparam logic [255:0] L4 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                   64'h5555AAAA5555AAAA, 64'h0F0F0F0F0F0F0F0F};
    localparam logic [255:0] D2 = {64'h9999999999999999, 64'h8888888888888888,
                                   64'h7777777777777777, 64'h6666666666666666};
    localparam logic [255:0] L6 = {64'h6000000000000004, 64'h6000000000000003,
                                   64'h6000000000000002, 64'h6000000000000001};
    localparam logic [255:0] L7 = {64'h7000000000000004, 64'h7000000000000003,
                                   64'h7000000000000002, 64'h7000000000000001};

    logic [255:0] line_v;

    cacheline_adapter #(.LINE_W(256), .BEAT_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts from the negedge of the RD_REQ cycle; ends on the negedge of the RESP cycle.
    task automatic feed_beats(input logic [255:0] line);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            bmem_rvalid = 1'b1;
            bmem_rdata  = line[b*64 +: 64];
        end
        @(negedge clk);
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
    endtask

    initial begin
        rst_n = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;

        @(negedge clk);
        chk("rst_resp", dfp_resp, 1'b0);
        chk("rst_bread", bmem_read, 1'b0);
        chk("rst_bwrite", bmem_write, 1'b0);
        chk("rst_baddr", bmem_addr, 32'h0);
        chk("rst_bwdata", bmem_wdata, 64'h0);
        chk("rst_rdata", dfp_rdata, 256'h0);
        rst_n = 1'b1;

        // basic read, with a stray rvalid during RD_REQ
        @(negedge clk);
        dfp_read = 1'b1; dfp_addr = 32'h1234_5678; bmem_ready = 1'b1;
        @(negedge clk);
        chk("t1_bread", bmem_read, 1'b1);
        chk("t1_baddr", bmem_addr, 32'h1234_5660);
        chk("t1_bwrite", bmem_write, 1'b0);
        bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        feed_beats(L1);
        chk("t1_resp", dfp_resp, 1'b1);
        chk("t1_rdata", dfp_rdata, L1);
        chk("t1_bread_off", bmem_read, 1'b0);
        dfp_read = 1'b0;
        @(negedge clk);
        chk("t1_resp_pulse", dfp_resp, 1'b0);

        // write burst; input data changes mid-burst must not leak through
        dfp_write = 1'b1; dfp_addr = 32'h0000_0040; dfp_wdata = D1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("t2_bwrite", bmem_write, 1'b1);
            chk("t2_bwdata", bmem_wdata, D1[b*64 +: 64]);
            chk("t2_baddr", bmem_addr, 32'h0000_0040);
            chk("t2_bread", bmem_read, 1'b0);
            chk("t2_resp_early", dfp_resp, 1'b0);
            dfp_wdata = '1;
        end
        @(negedge clk);
        chk("t2_resp", dfp_resp, 1'b1);
        chk("t2_bwrite_off", bmem_write, 1'b0);
        chk("t2_rdata_kept", dfp_rdata, L1);
        dfp_write = 1'b0;
        @(negedge clk);
        chk("t2_resp_pulse", dfp_resp, 1'b0);

        // gapped read: rvalid sampled at cycles 3, 7, 8, 12
        dfp_read = 1'b1; dfp_addr = 32'h0000_101F;
        k = 0;
        for (int c = 2; c <= 13; c++) begin
            @(negedge clk);
            chk("t3_resp", dfp_resp, (c == 13));
            chk("t3_bread", bmem_read, (c == 2));
            if (c == 3 || c == 7 || c == 8 || c == 12) begin
                line_v = L3;
                bmem_rvalid = 1'b1;
                bmem_rdata  = line_v[k*64 +: 64];
                k++;
            end else begin
                bmem_rvalid = 1'b0;
                bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            end
        end
        chk("t3_rdata", dfp_rdata, L3);
        dfp_read = 1'b0;
        @(negedge clk);
        chk("t3_resp_pulse", dfp_resp, 1'b0);

        // not ready for 5 cycles; ready dropped mid-burst has no effect
        bmem_ready = 1'b0; dfp_read = 1'b1; dfp_addr = 32'h0000_2004;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_bread_idle", bmem_read, 1'b0);
            chk("t4_bwrite_idle", bmem_write, 1'b0);
            chk("t4_baddr_idle", bmem_addr, 32'h0);
        end
        bmem_ready = 1'b1;
        @(negedge clk);
        chk("t4_bread", bmem_read, 1'b1);
        chk("t4_baddr", bmem_addr, 32'h0000_2000);
        bmem_ready = 1'b0;
        feed_beats(L4);
        chk("t4_resp", dfp_resp, 1'b1);
        chk("t4_rdata", dfp_rdata, L4);
        dfp_read = 1'b0;
        @(negedge clk);
        chk("t4_resp_pulse", dfp_resp, 1'b0);

        // read+write conflict, then reset after two write beats
        bmem_ready = 1'b1; dfp_read = 1'b1; dfp_write = 1'b1;
        dfp_addr = 32'h0000_0080; dfp_wdata = D2;
        @(negedge clk);
        chk("t5_bwrite0", bmem_write, 1'b1);
        chk("t5_bread0", bmem_read, 1'b0);
        chk("t5_bwdata0", bmem_wdata, 64'h6666666666666666);
        @(negedge clk);
        chk("t5_bwrite1", bmem_write, 1'b1);
        chk("t5_bwdata1", bmem_wdata, 64'h7777777777777777);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_bwrite", bmem_write, 1'b0);
        chk("t5_rst_bread", bmem_read, 1'b0);
        chk("t5_rst_baddr", bmem_addr, 32'h0);
        chk("t5_rst_bwdata", bmem_wdata, 64'h0);
        chk("t5_rst_resp", dfp_resp, 1'b0);
        chk("t5_rst_rdata", dfp_rdata, 256'h0);
        dfp_read = 1'b0; dfp_write = 1'b0;
        @(negedge clk);
        chk("t5_rst_hold", dfp_resp, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t5_post_resp", dfp_resp, 1'b0);
            chk("t5_post_bwrite", bmem_write, 1'b0);
            chk("t5_post_bread", bmem_read, 1'b0);
        end

        // back-to-back reads with dfp_read held through RESP
        dfp_read = 1'b1; dfp_addr = 32'h0000_0300;
        @(negedge clk);
        chk("t6_bread_a", bmem_read, 1'b1);
        chk("t6_baddr_a", bmem_addr, 32'h0000_0300);
        feed_beats(L6);
        chk("t6_resp_a", dfp_resp, 1'b1);
        chk("t6_rdata_a", dfp_rdata, L6);
        @(negedge clk);
        chk("t6_idle_resp", dfp_resp, 1'b0);
        chk("t6_idle_bread", bmem_read, 1'b0);
        @(negedge clk);
        chk("t6_bread_b", bmem_read, 1'b1);
        chk("t6_resp_gap", dfp_resp, 1'b0);
        feed_beats(L7);
        chk("t6_resp_b", dfp_resp, 1'b1);
        chk("t6_rdata_b", dfp_rdata, L7);
        dfp_read = 1'b0;
        @(negedge clk);
        chk("t6_resp_pulse", dfp_resp, 1'b0);
        chk("t6_end_bread", bmem_read, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
